// File: rtl/audio_tone_gen_if.sv
`default_nettype none
// ============================================================================
// Module : audio_tone_gen_if
// Brief  : valid/ready sample stream from the tone generator to the I2S serializer.
// Rev    : 1.0  initial release
// ============================================================================
interface audio_tone_gen_if #(
    parameter int SAMPLE_W = 16
);
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_data;
    logic                out_right;

    modport master (
        output out_valid,
        output out_data,
        output out_right,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_right,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/audio_tone_gen.sv
`default_nettype none
// ============================================================================
// Module : audio_tone_gen
// Brief  : phase-accumulator stereo test tone (saw/square/triangle/silence),
//          attenuated, streamed as left/right words. Triangle fold is compiled
//          in only when AUDIO_TONE_TRIANGLE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module audio_tone_gen #(
    parameter int PHASE_W  = 24,
    parameter int SAMPLE_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               enable,
    input  wire logic [PHASE_W-1:0] ftw,
    input  wire logic [1:0]         wave_sel,
    input  wire logic [3:0]         atten,
    input  wire logic               invert_r,
    audio_tone_gen_if.master        out_if,
    output      logic [15:0]        frame_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GEN   = 2'd1;
    localparam logic [1:0] S_LEFT  = 2'd2;
    localparam logic [1:0] S_RIGHT = 2'd3;

    localparam logic [SAMPLE_W-1:0] c_pos_fs = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] c_neg_fs = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};
    localparam logic [SAMPLE_W-1:0] c_min    = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [1:0]                r_state;
    logic [PHASE_W-1:0]        r_phase;
    logic [PHASE_W-1:0]        r_ftw_sh;
    logic [SAMPLE_W-1:0]       r_left;
    logic [SAMPLE_W-1:0]       r_right;
    logic [15:0]               r_frame;

    logic [SAMPLE_W-1:0]       w_top;
    logic [SAMPLE_W-1:0]       w_raw;
    logic signed [SAMPLE_W-1:0] w_left;
    logic [SAMPLE_W-1:0]       w_right;
    logic                      w_fire;

    assign w_top  = r_phase[PHASE_W-1 -: SAMPLE_W];
    assign w_fire = out_if.out_valid & out_if.out_ready;

`ifdef AUDIO_TONE_TRIANGLE_EN
    // Second half of the cycle folds the ramp back down by inverting the index.
    logic [SAMPLE_W-1:0] w_fold;
    assign w_fold = r_phase[PHASE_W-2 -: SAMPLE_W] ^ {SAMPLE_W{r_phase[PHASE_W-1]}};
`endif

    always_comb begin
        w_raw = '0;
        case (wave_sel)
            2'b00:   w_raw = {~w_top[SAMPLE_W-1], w_top[SAMPLE_W-2:0]};
            2'b01:   w_raw = r_phase[PHASE_W-1] ? c_neg_fs : c_pos_fs;
`ifdef AUDIO_TONE_TRIANGLE_EN
            2'b10:   w_raw = {~w_fold[SAMPLE_W-1], w_fold[SAMPLE_W-2:0]};
`else
            2'b10:   w_raw = '0;
`endif
            default: w_raw = '0;
        endcase
    end

    assign w_left = $signed(w_raw) >>> atten;

    // Negating the most negative code would wrap, so clamp it to +full scale.
    always_comb begin
        w_right = w_left;
        if (invert_r) begin
            w_right = (w_left == c_min) ? c_pos_fs : -w_left;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_ftw_sh <= '0;
            r_left   <= '0;
            r_right  <= '0;
            r_frame  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_GEN;
                    end
                end
                S_GEN: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ftw_sh <= ftw;
                        r_left   <= w_left;
                        r_right  <= w_right;
                        r_state  <= S_LEFT;
                    end
                end
                S_LEFT: begin
                    if (w_fire) begin
                        r_state <= S_RIGHT;
                    end
                end
                S_RIGHT: begin
                    if (w_fire) begin
                        r_phase <= r_phase + r_ftw_sh;
                        r_frame <= r_frame + 16'd1;
                        r_state <= S_GEN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_if.out_valid = (r_state == S_LEFT) | (r_state == S_RIGHT);
    assign out_if.out_right = (r_state == S_RIGHT);
    assign out_if.out_data  = (r_state == S_LEFT)  ? r_left  :
                              (r_state == S_RIGHT) ? r_right : '0;
    assign frame_cnt        = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_audio_tone_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_audio_tone_gen
// Brief  : directed and randomized bench for audio_tone_gen with an
//          arithmetic reference model of the tone waveforms.
// Rev    : 1.0  initial release
// ============================================================================
module tb_audio_tone_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] ftw = '0;
    logic [1:0]  wave_sel = '0;
    logic [3:0]  atten = '0;
    logic        invert_r = 1'b0;
    logic [15:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    audio_tone_gen_if #(.SAMPLE_W(16)) bus ();

    audio_tone_gen #(.PHASE_W(24), .SAMPLE_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .ftw      (ftw),
        .wave_sel (wave_sel),
        .atten    (atten),
        .invert_r (invert_r),
        .out_if   (bus),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial bus.out_ready = 1'b0;

    // Reference: waveform as plain signed arithmetic on the phase value.
    function automatic logic [15:0] model_sample(int p, int w, int a, bit inv, bit right);
        int s;
        int q;
        s = 0;
        case (w)
            0: s = (p >> 8) - 32768;
            1: s = (p < 32'h800000) ? 32767 : -32767;
`ifdef AUDIO_TONE_TRIANGLE_EN
            2: begin
                q = (p & 32'h7FFFFF) >> 7;
                if (p >= 32'h800000) q = 65535 - q;
                s = q - 32768;
            end
`endif
            default: s = 0;
        endcase
        s = s >>> a;
        if (right && inv) s = (s == -32768) ? 32767 : -s;
        return s[15:0];
    endfunction

    task automatic do_reset();
        enable = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Accept the next word with ready high; bounded wait.
    task automatic take_word(output logic [15:0] d, output logic r, output bit ok);
        ok = 1'b0;
        d = '0;
        r = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                d = bus.out_data;
                r = bus.out_right;
                @(posedge clk);
                #1;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        vectors++;
        if (bus.out_right !== 1'b0) begin miscompares++; $display("FAIL reset_right got %b want 0", bus.out_right); end
        vectors++;
        if (bus.out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data got %h want 0000", bus.out_data); end
        vectors++;
        if (frame_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saw();
        logic [15:0] d, l;
        logic r;
        bit ok;
        do_reset();
        ftw = 24'h100000; wave_sel = 2'b00; atten = 4'd0; invert_r = 1'b0;
        bus.out_ready = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL saw_latency1 valid got %b want 0", bus.out_valid); end
        @(posedge clk); #1;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8000)
            begin miscompares++; $display("FAIL saw_latency2 valid/data got %b/%h want 1/8000", bus.out_valid, bus.out_data); end
        for (int k = 0; k < 17; k++) begin
            take_word(l, r, ok);
            vectors++;
            if (!ok || r !== 1'b0 || l !== 16'(32'h8000 + (k % 16) * 32'h1000))
                begin miscompares++; $display("FAIL saw_left[%0d] got %h r=%b ok=%0d want %h", k, l, r, ok, 16'(32'h8000 + (k % 16) * 32'h1000)); end
            take_word(d, r, ok);
            vectors++;
            if (!ok || r !== 1'b1 || d !== l)
                begin miscompares++; $display("FAIL saw_right[%0d] got %h r=%b want %h", k, d, r, l); end
            if (k == 15) begin
                vectors++;
                if (frame_cnt !== 16'd16) begin miscompares++; $display("FAIL saw_frame_cnt got %0d want 16", frame_cnt); end
            end
        end
    endtask

    task automatic test_square();
        logic [15:0] d;
        logic r;
        bit ok;
        logic [15:0] want;
        for (int inv = 0; inv < 2; inv++) begin
            do_reset();
            ftw = 24'h400000; wave_sel = 2'b01; atten = 4'd4; invert_r = inv[0];
            enable = 1'b1;
            for (int k = 0; k < 8; k++) begin
                take_word(d, r, ok);
                want = ((k % 4) < 2) ? 16'h07FF : 16'hF800;
                vectors++;
                if (!ok || d !== want) begin miscompares++; $display("FAIL square_left inv=%0d k=%0d got %h want %h", inv, k, d, want); end
                take_word(d, r, ok);
                if (inv == 1) want = ((k % 4) < 2) ? 16'hF801 : 16'h0800;
                vectors++;
                if (!ok || d !== want || r !== 1'b1) begin miscompares++; $display("FAIL square_right inv=%0d k=%0d got %h want %h", inv, k, d, want); end
            end
        end
    endtask

    task automatic test_triangle();
        logic [15:0] d;
        logic r;
        bit ok;
        logic [15:0] tri_tab [0:8];
        tri_tab = '{16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h7FFF,
                    16'h3FFF, 16'hFFFF, 16'hBFFF, 16'h8000};
        do_reset();
        ftw = 24'h200000; wave_sel = 2'b10; atten = 4'd0; invert_r = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            take_word(d, r, ok);
`ifdef AUDIO_TONE_TRIANGLE_EN
            vectors++;
            if (!ok || d !== tri_tab[k]) begin miscompares++; $display("FAIL triangle_left k=%0d got %h want %h", k, d, tri_tab[k]); end
`else
            vectors++;
            if (!ok || d !== 16'h0000) begin miscompares++; $display("FAIL triangle_off k=%0d got %h want 0000", k, d); end
`endif
            take_word(d, r, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        bit seen;
        do_reset();
        ftw = 24'h100000; wave_sel = 2'b00; atten = 4'd0; invert_r = 1'b0;
        enable = 1'b1;
        bus.out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL bp_valid_timeout got 0 want 1"); end
        held = bus.out_data;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_right !== w[0] || bus.out_data !== held || frame_cnt !== 16'd0)
                    begin miscompares++; $display("FAIL bp_hold w=%0d got v=%b r=%b d=%h fc=%0d want 1/%0d/%h/0", w, bus.out_valid, bus.out_right, bus.out_data, frame_cnt, w, held); end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        vectors++;
        if (frame_cnt !== 16'd1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_frame got fc=%0d v=%b want 1/0", frame_cnt, bus.out_valid); end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_right !== 1'b0 || bus.out_data !== 16'h9000)
            begin miscompares++; $display("FAIL bp_next_left got v=%b r=%b d=%h want 1/0/9000", bus.out_valid, bus.out_right, bus.out_data); end
    endtask

    task automatic test_enable_reset();
        logic [15:0] d;
        logic r;
        bit ok;
        do_reset();
        ftw = 24'h100000; wave_sel = 2'b00; atten = 4'd0; invert_r = 1'b0;
        enable = 1'b1;
        take_word(d, r, ok);
        enable = 1'b0;
        take_word(d, r, ok);
        vectors++;
        if (!ok || r !== 1'b1 || d !== 16'h8000) begin miscompares++; $display("FAIL en_drop_right got %h r=%b ok=%0d want 8000 r=1", d, r, ok); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b0 || frame_cnt !== 16'd1)
                begin miscompares++; $display("FAIL en_drop_idle got v=%b fc=%0d want 0/1", bus.out_valid, frame_cnt); end
        end
        bus.out_ready = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || frame_cnt !== 16'd0)
            begin miscompares++; $display("FAIL async_reset got v=%b d=%h fc=%0d want 0/0000/0", bus.out_valid, bus.out_data, frame_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8000)
            begin miscompares++; $display("FAIL post_reset_first got v=%b d=%h want 1/8000", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_random();
        int exp_phase, exp_frames;
        bit exp_word;
        int s_ftw, s_wave, s_atten;
        bit s_inv, fire;
        logic [15:0] want;
        do_reset();
        ftw = 24'($urandom); wave_sel = 2'($urandom); atten = 4'($urandom); invert_r = 1'($urandom);
        s_ftw = int'(ftw); s_wave = int'(wave_sel); s_atten = int'(atten); s_inv = invert_r;
        exp_phase = 0; exp_frames = 0; exp_word = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            bus.out_ready = ($urandom % 4) != 0;
            if (bus.out_valid && ($urandom % 6) == 0) begin
                case ($urandom % 4)
                    0: ftw = 24'h000000;
                    1: ftw = 24'h800000;
                    default: ftw = 24'($urandom);
                endcase
                wave_sel = 2'($urandom); atten = 4'($urandom); invert_r = 1'($urandom);
            end
            if (bus.out_valid) begin
                want = model_sample(exp_phase, s_wave, s_atten, s_inv, exp_word);
                vectors++;
                if (bus.out_right !== exp_word || bus.out_data !== want)
                    begin miscompares++; $display("FAIL rand_word c=%0d got r=%b d=%h want r=%b d=%h", c, bus.out_right, bus.out_data, exp_word, want); end
            end
            fire = bus.out_valid && bus.out_ready;
            if (fire && exp_word) begin
                exp_phase = (exp_phase + s_ftw) & 32'hFFFFFF;
                exp_frames++;
                s_ftw = int'(ftw); s_wave = int'(wave_sel); s_atten = int'(atten); s_inv = invert_r;
            end
            if (fire) exp_word = ~exp_word;
            @(posedge clk);
        end
        @(negedge clk);
        vectors++;
        if (frame_cnt !== 16'(exp_frames) || exp_frames < 100)
            begin miscompares++; $display("FAIL rand_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_square();
        test_triangle();
        test_backpressure();
        test_enable_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
